// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and PC arithmetic for the IF stage.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);

  logic [31:0] instr_q;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_q;
  logic [31:0] pc_plus4_d;
  logic        valid_q;
  logic        valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = 32'h0000_0000;
      valid_d    = 1'b0;
    end else if (stall) begin
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
    end else if (load) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end else begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = 32'h0000_0000;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, instruction-memory request/ready handshake and the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        JumpEnable,
  input  logic [31:0] JumpAddress,
  input  logic        BranchTaken,
  input  logic [31:0] BranchAddress,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemRData,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pcf_q;
  logic [31:0]  pcf_d;
  logic [31:0]  redir_q;
  logic [31:0]  redir_d;
  logic [31:0]  hold_instr_q;
  logic [31:0]  hold_instr_d;
  logic [31:0]  hold_pc4_q;
  logic [31:0]  hold_pc4_d;
  logic         req_q;
  logic         req_d;

  logic         redirect_s;
  logic         stall_s;
  logic [31:0]  target_s;
  logic [31:0]  pcf_plus4_s;
  logic         deliver_s;
  logic [31:0]  deliver_instr_s;
  logic [31:0]  deliver_pc4_s;

  // A redirect while D is stalled is ignored; D presents it again later.
  assign redirect_s  = (JumpEnable | BranchTaken) & ~StallD;
  assign target_s    = BranchTaken ? BranchAddress : JumpAddress;
  assign stall_s     = StallF | StallD;
  assign pcf_plus4_s = pc_plus4(pcf_q);

  always_comb begin
    state_d         = state_q;
    pcf_d           = pcf_q;
    redir_d         = redir_q;
    hold_instr_d    = hold_instr_q;
    hold_pc4_d      = hold_pc4_q;
    deliver_s       = 1'b0;
    deliver_instr_s = NOP_INSTR;
    deliver_pc4_s   = 32'h0000_0000;
    case (state_q)
      ST_RUN: begin
        if (!req_q) begin
          if (redirect_s) begin
            pcf_d = target_s;
          end else begin
            pcf_d = pcf_q;
          end
        end else if (ImemReady) begin
          if (redirect_s) begin
            pcf_d = target_s;
          end else if (!stall_s) begin
            deliver_s       = 1'b1;
            deliver_instr_s = ImemRData;
            deliver_pc4_s   = pcf_plus4_s;
            pcf_d           = pcf_plus4_s;
          end else begin
            hold_instr_d = ImemRData;
            hold_pc4_d   = pcf_plus4_s;
            pcf_d        = pcf_plus4_s;
            state_d      = ST_HOLD;
          end
        end else if (redirect_s) begin
          // The request must stay stable, so park the target until it completes.
          redir_d = target_s;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (redirect_s) begin
          redir_d = target_s;
        end else begin
          redir_d = redir_q;
        end
        if (ImemReady) begin
          pcf_d   = redir_d;
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (redirect_s) begin
          pcf_d   = target_s;
          state_d = ST_RUN;
        end else if (!stall_s) begin
          deliver_s       = 1'b1;
          deliver_instr_s = hold_instr_q;
          deliver_pc4_s   = hold_pc4_q;
          state_d         = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_RUN;
        pcf_d   = RESET_PC;
      end
    endcase
    req_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pcf_q        <= RESET_PC;
      redir_q      <= 32'h0000_0000;
      hold_instr_q <= NOP_INSTR;
      hold_pc4_q   <= 32'h0000_0000;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      redir_q      <= redir_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      req_q        <= req_d;
    end
  end

  if_id_reg u_if_id (
    .clk          (clk),
    .rst          (reset),
    .flush        (FlushD | redirect_s),
    .stall        (StallD),
    .load         (deliver_s),
    .instr_in     (deliver_instr_s),
    .pc_plus4_in  (deliver_pc4_s),
    .instr_out    (InstrD),
    .pc_plus4_out (PCPlus4D),
    .valid_out    (ValidD)
  );

  assign ImemReq  = req_q;
  assign ImemAddr = {pcf_q[31:2], 2'b00};
  assign PCF      = pcf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus a randomized instruction-stream check for fetch_unit.
module tb_fetch_unit;

  localparam logic [31:0] DATA_OFS = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, StallF, StallD, FlushD, JumpEnable, BranchTaken, ImemReady;
  logic [31:0] JumpAddress, BranchAddress, ImemRData, w_ImemRData;
  logic        ImemReq, ValidD, w_ImemReq, w_ValidD;
  logic [31:0] ImemAddr, PCF, InstrD, PCPlus4D;
  logic [31:0] w_ImemAddr, w_PCF, w_InstrD, w_PCPlus4D;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .JumpEnable(JumpEnable), .JumpAddress(JumpAddress), .BranchTaken(BranchTaken),
    .BranchAddress(BranchAddress), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemReady(ImemReady), .ImemRData(ImemRData), .PCF(PCF), .InstrD(InstrD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .JumpEnable(JumpEnable), .JumpAddress(JumpAddress), .BranchTaken(BranchTaken),
    .BranchAddress(BranchAddress), .ImemReq(w_ImemReq), .ImemAddr(w_ImemAddr),
    .ImemReady(ImemReady), .ImemRData(w_ImemRData), .PCF(w_PCF), .InstrD(w_InstrD),
    .PCPlus4D(w_PCPlus4D), .ValidD(w_ValidD)
  );

  // Memory returns address + 0x100 for whatever address is currently requested.
  task automatic mem_respond();
    ImemRData   = ImemAddr + DATA_OFS;
    w_ImemRData = w_ImemAddr + DATA_OFS;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    mem_respond();
  endtask

  task automatic test_reset();
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    JumpEnable = 1'b0; BranchTaken = 1'b0; ImemReady = 1'b0;
    JumpAddress = 32'h0; BranchAddress = 32'h0; ImemRData = 32'h0; w_ImemRData = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", ImemReq); end
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL rst_pcf: got %h expected 0", PCF); end
    checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", InstrD); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h expected 0", PCPlus4D); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", ValidD); end
    checks++; if (w_PCF !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_w_pcf: got %h expected fffffffc", w_PCF); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    reset = 1'b0; ImemReady = 1'b1; mem_respond();
    tick();
    checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL zw_req_up: got %b expected 1", ImemReq); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL zw_first_valid: got %b expected 0", ValidD); end
    for (int i = 0; i < 3; i++) begin
      a = 32'(i) * 32'd4;
      checks++; if (ImemAddr !== a) begin errors++; $display("FAIL zw_addr[%0d]: got %h expected %h", i, ImemAddr, a); end
      tick();
      checks++; if (ValidD !== 1'b1 || InstrD !== a + DATA_OFS || PCPlus4D !== a + 32'd4) begin
        errors++; $display("FAIL zw_ifid[%0d]: got v=%b i=%h p=%h expected v=1 i=%h p=%h", i, ValidD, InstrD, PCPlus4D, a + DATA_OFS, a + 32'd4);
      end
    end
  endtask

  task automatic test_jump();
    tick();
    checks++; if (PCF !== 32'h10) begin errors++; $display("FAIL jmp_pre_pcf: got %h expected 10", PCF); end
    JumpEnable = 1'b1; JumpAddress = 32'h0040_0020;
    tick();
    JumpEnable = 1'b0;
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL jmp_bubble: got %b expected 0", ValidD); end
    checks++; if (PCF !== 32'h0040_0020) begin errors++; $display("FAIL jmp_pcf: got %h expected 00400020", PCF); end
    tick();
    checks++; if (ValidD !== 1'b1 || PCPlus4D !== 32'h0040_0024 || InstrD !== 32'h0040_0120) begin
      errors++; $display("FAIL jmp_target: got v=%b p=%h i=%h expected v=1 p=00400024 i=00400120", ValidD, PCPlus4D, InstrD);
    end
  endtask

  task automatic test_branch_wait();
    JumpEnable = 1'b1; JumpAddress = 32'h8;
    tick();
    JumpEnable = 1'b0;
    checks++; if (ImemAddr !== 32'h8) begin errors++; $display("FAIL bw_pre_addr: got %h expected 8", ImemAddr); end
    // Branch and jump together: branch target must win.
    ImemReady = 1'b0; BranchTaken = 1'b1; BranchAddress = 32'h200; JumpEnable = 1'b1; JumpAddress = 32'h7000;
    tick();
    BranchTaken = 1'b0; JumpEnable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h8 || ValidD !== 1'b0) begin
        errors++; $display("FAIL bw_wait[%0d]: got req=%b addr=%h v=%b expected req=1 addr=8 v=0", k, ImemReq, ImemAddr, ValidD);
      end
      if (k < 2) tick();
    end
    ImemReady = 1'b1;
    tick();
    checks++; if (ValidD !== 1'b0 || ImemAddr !== 32'h200) begin
      errors++; $display("FAIL bw_stale: got v=%b addr=%h expected v=0 addr=200", ValidD, ImemAddr);
    end
    tick();
    checks++; if (ValidD !== 1'b1 || InstrD !== 32'h300 || PCPlus4D !== 32'h204) begin
      errors++; $display("FAIL bw_target: got v=%b i=%h p=%h expected v=1 i=300 p=204", ValidD, InstrD, PCPlus4D);
    end
  endtask

  task automatic test_stall_hold();
    StallF = 1'b1; StallD = 1'b1; ImemRData = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (ImemReq !== 1'b0 || InstrD !== 32'h300 || PCPlus4D !== 32'h204 || ValidD !== 1'b1) begin
        errors++; $display("FAIL sh_hold[%0d]: got req=%b i=%h p=%h v=%b expected req=0 i=300 p=204 v=1", k, ImemReq, InstrD, PCPlus4D, ValidD);
      end
    end
    StallF = 1'b0; StallD = 1'b0;
    tick();
    checks++; if (InstrD !== 32'hDEAD_BEEF || PCPlus4D !== 32'h208 || ValidD !== 1'b1) begin
      errors++; $display("FAIL sh_release: got i=%h p=%h v=%b expected i=deadbeef p=208 v=1", InstrD, PCPlus4D, ValidD);
    end
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h208) begin
      errors++; $display("FAIL sh_resume_addr: got req=%b addr=%h expected req=1 addr=208", ImemReq, ImemAddr);
    end
    tick();
    checks++; if (InstrD !== 32'h308 || PCPlus4D !== 32'h20C) begin
      errors++; $display("FAIL sh_next: got i=%h p=%h expected i=308 p=20c", InstrD, PCPlus4D);
    end
  endtask

  task automatic test_flush();
    FlushD = 1'b1;
    tick();
    FlushD = 1'b0;
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus4D !== 32'h0 || PCF !== 32'h210) begin
      errors++; $display("FAIL fl_bubble: got v=%b i=%h p=%h pcf=%h expected v=0 i=0 p=0 pcf=210", ValidD, InstrD, PCPlus4D, PCF);
    end
    tick();
    checks++; if (ValidD !== 1'b1 || InstrD !== 32'h310 || PCPlus4D !== 32'h214) begin
      errors++; $display("FAIL fl_after: got v=%b i=%h p=%h expected v=1 i=310 p=214", ValidD, InstrD, PCPlus4D);
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; ImemReady = 1'b1; mem_respond();
    tick();
    checks++; if (w_ImemReq !== 1'b1 || w_ImemAddr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wr_first: got req=%b addr=%h expected req=1 addr=fffffffc", w_ImemReq, w_ImemAddr);
    end
    tick();
    checks++; if (w_ImemAddr !== 32'h0 || w_PCPlus4D !== 32'h0 || w_InstrD !== 32'h0000_00FC || w_ValidD !== 1'b1) begin
      errors++; $display("FAIL wr_wrap: got addr=%h p=%h i=%h v=%b expected addr=0 p=0 i=fc v=1", w_ImemAddr, w_PCPlus4D, w_InstrD, w_ValidD);
    end
  endtask

  task automatic test_reset_midwait();
    ImemReady = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ImemReq !== 1'b0 || PCF !== 32'h0 || InstrD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin
      errors++; $display("FAIL mr_main: got req=%b pcf=%h i=%h p=%h v=%b expected all 0", ImemReq, PCF, InstrD, PCPlus4D, ValidD);
    end
    checks++; if (w_ImemReq !== 1'b0 || w_PCF !== 32'hFFFF_FFFC || w_ValidD !== 1'b0 || w_PCPlus4D !== 32'h0) begin
      errors++; $display("FAIL mr_wrap: got req=%b pcf=%h v=%b p=%h expected req=0 pcf=fffffffc v=0 p=0", w_ImemReq, w_PCF, w_ValidD, w_PCPlus4D);
    end
    @(negedge clk);
  endtask

  // Stream model: valid instructions appear in program order; a taken redirect
  // squashes everything in flight and restarts the stream at its target.
  task automatic test_random();
    logic [31:0] exp_pc, target, prev_addr, prev_instr, prev_pc4;
    logic        prev_req, prev_ready, prev_valid, jmp, br, sf, sd, redir;
    int          delivered;
    exp_pc = 32'h0; delivered = 0;
    reset = 1'b0; ImemReady = 1'b0; mem_respond();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      jmp = ($urandom_range(0, 15) == 0);
      br  = ($urandom_range(0, 15) == 0);
      sf  = ($urandom_range(0, 4) == 0);
      sd  = sf & ($urandom_range(0, 1) == 1);
      JumpEnable = jmp; BranchTaken = br; StallF = sf; StallD = sd;
      JumpAddress   = $urandom & 32'hFFFF_FFFC;
      BranchAddress = $urandom & 32'hFFFF_FFFC;
      ImemReady = ($urandom_range(0, 9) < 7);
      redir  = (jmp | br) & ~sd;
      target = br ? BranchAddress : JumpAddress;
      prev_req = ImemReq; prev_addr = ImemAddr; prev_ready = ImemReady;
      prev_instr = InstrD; prev_pc4 = PCPlus4D; prev_valid = ValidD;
      tick();
      if (prev_req && !prev_ready) begin
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== prev_addr) begin
          errors++; $display("FAIL rnd_handshake cyc=%0d: got req=%b addr=%h expected req=1 addr=%h", cyc, ImemReq, ImemAddr, prev_addr);
        end
      end
      if (redir) begin
        checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin
          errors++; $display("FAIL rnd_squash cyc=%0d: got v=%b i=%h expected v=0 i=0", cyc, ValidD, InstrD);
        end
        exp_pc = target;
      end else if (sd) begin
        checks++; if (InstrD !== prev_instr || PCPlus4D !== prev_pc4 || ValidD !== prev_valid) begin
          errors++; $display("FAIL rnd_stall cyc=%0d: got i=%h p=%h v=%b expected i=%h p=%h v=%b", cyc, InstrD, PCPlus4D, ValidD, prev_instr, prev_pc4, prev_valid);
        end
      end else if (ValidD === 1'b1) begin
        checks++; if (PCPlus4D !== exp_pc + 32'd4 || InstrD !== exp_pc + DATA_OFS) begin
          errors++; $display("FAIL rnd_stream cyc=%0d: got p=%h i=%h expected p=%h i=%h", cyc, PCPlus4D, InstrD, exp_pc + 32'd4, exp_pc + DATA_OFS);
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    JumpEnable = 1'b0; BranchTaken = 1'b0; StallF = 1'b0; StallD = 1'b0;
    checks++; if (delivered < 300) begin
      errors++; $display("FAIL rnd_progress: got %0d deliveries expected at least 300", delivered);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_jump();
    test_branch_wait();
    test_stall_hold();
    test_flush();
    test_wrap();
    test_reset_midwait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- IF stage of the 5-stage pipeline: owns the PC register, drives the instruction-memory request/ready handshake, and holds the IF/ID pipeline register.
- Consumes `JumpAddress`/`JumpEnable` from the D-stage jump unit and `BranchTaken`/`BranchAddress` from branch resolution.
- Produces `InstrD` and `PCPlus4D` for decode; `PCPlus4D` also feeds the jump unit's region bits.
- No delay slot: the fetch-stage instruction behind a taken jump or branch is squashed.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- StallF  in  1  hazard unit: freeze the fetch stage.
- StallD  in  1  hazard unit: hold IF/ID. The hazard unit never drives StallD=1 with StallF=0; internally, stall = StallF|StallD.
- FlushD  in  1  load a bubble into IF/ID.
- JumpEnable  in  1  jump decoded in D.
- JumpAddress  in  32  jump target.
- BranchTaken  in  1  branch resolved taken in D.
- BranchAddress  in  32  branch target.
- ImemReq  out  1  fetch request valid.
- ImemAddr  out  32  fetch address, {PCF[31:2],2'b00}.
- ImemReady  in  1  same-cycle completion; ImemRData is valid for ImemAddr.
- ImemRData  in  32  fetched word.
- PCF  out  32  current fetch PC.
- InstrD  out  32  IF/ID instruction.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction.

## Operation
- Handshake: once ImemReq=1 is driven with an address, ImemReq and ImemAddr stay stable until a cycle with ImemReady=1. Zero-wait memory completes in the same cycle.
- Redirect = (JumpEnable|BranchTaken) & !StallD. BranchAddress wins if both are asserted. A redirect while StallD=1 is ignored; D re-presents it.
- FSM states:
  - RUN: ImemReq=1, ImemAddr=PCF.
    - ImemReady & redirect: discard data; PCF<=target.
    - ImemReady & !stall: deliver ImemRData; PCF<=PCF+4.
    - ImemReady & stall: capture ImemRData/PCF+4 into the hold buffer; PCF<=PCF+4; go to HOLD.
    - !ImemReady & redirect: latch target into RedirPC; go to DRAIN.
  - DRAIN: ImemReq=1, address unchanged. On ImemReady: discard data, PCF<=RedirPC, go to RUN. A further redirect overwrites RedirPC.
  - HOLD: ImemReq=0.
    - redirect: drop the buffer; PCF<=target; go to RUN.
    - !stall: deliver the buffer; go to RUN.
- IF/ID update priority: reset > FlushD or redirect (InstrD=0, PCPlus4D=0, ValidD=0) > StallD (hold) > delivery (InstrD=word, PCPlus4D=fetch PC+4, ValidD=1) > bubble (InstrD=0, ValidD=0).
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- Target bits [1:0] are ignored on ImemAddr but kept in PCF.

## Timing
- Reset values: PCF=RESET_PC, state RUN, ImemReq=0 while reset is asserted and 1 in the first cycle after release. InstrD=0, PCPlus4D=0, ValidD=0, hold buffer empty, RedirPC=0.
- Zero-wait memory: one instruction per cycle; 1-cycle fetch-to-D latency.
- Redirect asserted in cycle t, memory ready:
  - t+1: PCF=target, IF/ID bubble.
  - t+2: target instruction in D.
- N wait states: ValidD=0 for N cycles per fetch.
- Redirect during a wait: the stale response is dropped. The first fetch at the target issues the cycle after the stale ImemReady.
- Reset mid-transaction: abandons the request; the memory must tolerate ImemReq falling.

## Structure
- Shared package: NOP_INSTR (32'h0), default RESET_PC, fetch state encoding (RUN, DRAIN, HOLD).
- Sub-module if_id_reg: 32+32+1-bit register with flush/stall priority, instantiated once.
- FSM, PC, hold buffer and RedirPC live in fetch_unit.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory returning addr+0x100 → ImemAddr 0,4,8 on consecutive cycles; ValidD=1 with InstrD=0x100,0x104,0x108; PCPlus4D=4,8,12.
- JumpEnable=1, JumpAddress=0x0040_0020 while PCF=0x10 → next cycle ValidD=0, PCF=0x0040_0020; following cycle PCPlus4D=0x0040_0024.
- ImemReady low 3 cycles at PCF=0x8, BranchTaken=1 (target 0x200) on the first wait cycle → ImemAddr stays 0x8 until ready; data discarded (ValidD=0); next ImemAddr=0x200.
- StallF=StallD=1 in the cycle ImemReady returns word 0xDEAD_BEEF → ImemReq=0 and IF/ID held. After the stall drops: InstrD=0xDEAD_BEEF, then fetch resumes at PC+4.
- RESET_PC=32'hFFFF_FFFC, zero-wait → second ImemAddr=0, PCPlus4D=0; assert reset mid-wait → all outputs at reset values asynchronously.
